// File: rtl/cs_result_fifo.sv
// Result FIFO behind the CS averaging stage: drops warm-up results and buffers the rest for a stalling consumer.
// Optional CS_PEAK_EN adds a running maximum of accepted results on the peak port.
module cs_result_fifo #(
  parameter int DEPTH  = 8,
  parameter int WARMUP = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     x_strobe,
  input  logic [9:0]               y_in,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [9:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
`ifdef CS_PEAK_EN
  ,
  output logic [9:0]               peak
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (WARMUP > 2) ? $clog2(WARMUP) : 1;
  localparam logic [WW-1:0] WLAST  = WW'(WARMUP - 1);
  localparam logic [CW-1:0] CDEPTH = CW'(DEPTH);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [WW-1:0] wcnt;
  logic          cap;
  logic          pop;
  logic          push;
  logic          wr;

  assign out_valid = (count != '0);
  assign full      = (count == CDEPTH);
  assign pop       = out_valid & out_ready;
  assign push      = cap & (wcnt == WLAST);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr        = push & (~full | pop);
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap      <= 1'b0;
      wcnt     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      cap   <= 1'b0;
      wcnt  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      cap <= x_strobe;
      if (cap && (wcnt != WLAST))
        wcnt <= wcnt + WW'(1);
      if (wr)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      count <= count + CW'(wr) - CW'(pop);
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr && !flush)
      mem[wptr] <= y_in;
  end

`ifdef CS_PEAK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      peak <= '0;
    else if (flush)
      peak <= '0;
    else if (wr && (y_in > peak))
      peak <= y_in;
  end
`endif

endmodule

// File: tb/tb_cs_result_fifo.sv
// Self-checking bench for cs_result_fifo: directed scenarios plus random traffic against a queue model.
module tb_cs_result_fifo;

  localparam int DEPTH  = 8;
  localparam int WARMUP = 9;

  logic       clk;
  logic       reset;
  logic       x_strobe;
  logic [9:0] y_in;
  logic       flush;
  logic       out_ready;
  logic       out_valid;
  logic [9:0] out_data;
  logic [3:0] count;
  logic       full;
  logic       overflow;
`ifdef CS_PEAK_EN
  logic [9:0] peak;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int mq[$];
  int mw    = 0;
  bit mcap  = 0;
  bit movf  = 0;
  int mpeak = 0;

  cs_result_fifo #(.DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk       (clk),
    .reset     (reset),
    .x_strobe  (x_strobe),
    .y_in      (y_in),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
`ifdef CS_PEAK_EN
    ,
    .peak      (peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mw = 0; mcap = 0; movf = 0; mpeak = 0;
    end else if (flush) begin
      mq.delete();
      mw = 0; mcap = 0; mpeak = 0;
    end else begin
      bit ev;
      bit do_push;
      ev = mcap;
      do_push = 0;
      if (ev) begin
        if (mw < WARMUP - 1) mw++;
        else do_push = 1;
      end
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(int'(y_in));
          if (int'(y_in) > mpeak) mpeak = int'(y_in);
        end else begin
          movf = 1;
        end
      end
      mcap = x_strobe;
    end
  end

  always @(negedge clk) begin
    check("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("m_out_data",  32'(out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check("m_count",     32'(count),     32'(mq.size()));
    check("m_full",      32'(full),      32'(mq.size() == DEPTH));
    check("m_overflow",  32'(overflow),  32'(movf));
`ifdef CS_PEAK_EN
    check("m_peak",      32'(peak),      32'(mpeak));
`endif
  end

  task automatic cyc(input logic s, input logic [9:0] y, input logic r, input logic f);
    x_strobe  = s;
    y_in      = y;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [9:0] v, input logic r);
    cyc(1'b1, 10'h0, r, 1'b0);
    cyc(1'b0, v, r, 1'b0);
  endtask

  task automatic async_reset_pulse();
    #2;
    reset = 1'b0;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; x_strobe = 1'b0; y_in = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_count", 32'(count),     32'd0);
    check("rst_full",  32'(full),      32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    reset = 1'b1;

    // Warm-up: eight results dropped, ninth appears two cycles after its strobe
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 10'h3FF, 1'b1, 1'b0);
      check("warm_count", 32'(count), 32'd0);
      check("warm_valid", 32'(out_valid), 32'd0);
    end
    cyc(1'b1, 10'h123, 1'b1, 1'b0);
    check("warm9_count0", 32'(count), 32'd0);
    cyc(1'b0, 10'h123, 1'b1, 1'b0);
    check("warm9_valid", 32'(out_valid), 32'd1);
    check("warm9_data",  32'(out_data),  32'h123);
    cyc(1'b0, 10'h0, 1'b1, 1'b0);
    check("warm9_popped", 32'(out_valid), 32'd0);

    // Fill and overflow with results 1..10
    for (int i = 0; i <= 10; i++)
      cyc(i < 10, 10'(i), 1'b0, 1'b0);
    check("fill_count", 32'(count), 32'd8);
    check("fill_full",  32'(full),  32'd1);
    check("fill_ovf",   32'(overflow), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data",  32'(out_data),  32'(k));
      cyc(1'b0, 10'h0, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_ovf",   32'(overflow),  32'd1);

    // Five entries, then asynchronous reset between edges
    for (int i = 0; i <= 5; i++)
      cyc(i < 5, 10'(i + 'h40), 1'b0, 1'b0);
    check("five_count", 32'(count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(count),     32'd0);
    check("arst_ovf",   32'(overflow),  32'd0);
    check("arst_data",  32'(out_data),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Warm-up again, fill, then push and pop together while full
    for (int c = 0; c < 40; c++) begin
      if (c == 9) check("rewarm_count", 32'(count), 32'd0);
      if (c >= 17) begin
        check("fullpp_count", 32'(count),    32'd8);
        check("fullpp_full",  32'(full),     32'd1);
        check("fullpp_ovf",   32'(overflow), 32'd0);
        check("fullpp_data",  32'(out_data), 32'(c - 16));
      end
      cyc(1'b1, (c >= 9) ? 10'(c - 8) : 10'h0, c >= 17, 1'b0);
    end
    cyc(1'b1, 10'd32, 1'b0, 1'b0);
    check("stall_ovf", 32'(overflow), 32'd1);

    // Flush beats a coincident capture and pop, keeps overflow
    cyc(1'b1, 10'd33, 1'b1, 1'b1);
    check("flush_count", 32'(count),     32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ovf",   32'(overflow),  32'd1);
    for (int j = 0; j < 10; j++) begin
      cyc(j < 9, 10'h055, 1'b0, 1'b0);
      check("flush_rewarm", 32'(count), (j == 9) ? 32'd1 : 32'd0);
    end
    check("flush_rewarm_data", 32'(out_data), 32'h055);

`ifdef CS_PEAK_EN
    cyc(1'b0, 10'h0, 1'b0, 1'b1);
    check("peak_flush0", 32'(peak), 32'd0);
    repeat (8) push_one(10'h3FF, 1'b1);
    check("peak_warm", 32'(peak), 32'd0);
    push_one(10'h050, 1'b0);
    push_one(10'h2A0, 1'b0);
    push_one(10'h100, 1'b0);
    check("peak_max",   32'(peak),  32'h2A0);
    check("peak_count", 32'(count), 32'd3);
    for (int i = 1; i <= 5; i++) push_one(10'(i), 1'b0);
    check("peak_full", 32'(full), 32'd1);
    push_one(10'h3FF, 1'b0);
    check("peak_dropped", 32'(peak), 32'h2A0);
    cyc(1'b0, 10'h0, 1'b0, 1'b1);
    check("peak_flushed", 32'(peak), 32'd0);
`endif

    // Random traffic with varying consumer pressure
    for (int n = 0; n < 3000; n++) begin
      int rsel;
      rsel = (n / 200) % 3;
      if ($urandom_range(0, 399) == 0) begin
        async_reset_pulse();
      end else begin
        cyc(($urandom_range(0, 3) != 0),
            10'($urandom_range(0, 1023)),
            (rsel == 0) ? ($urandom_range(0, 3) != 0) :
            (rsel == 1) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1),
            ($urandom_range(0, 149) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
